// File: rtl/prbs7_pkg.sv
// prbs7_pkg: shared PRBS7 taps, default seed, injection FSM states and word-step helper
package prbs7_pkg;
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;
  localparam logic [6:0] PRBS7_DEFAULT_SEED = 7'h7F;
  typedef enum logic {IDLE, WAIT_REL} inj_state_t;
  function automatic logic [70:0] prbs7_next_word(input logic [6:0] state, input int width);
    logic [6:0] s;
    logic [63:0] w;
    s = state;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        w[i] = s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
        s = {s[5:0], w[i]};
      end
    end
    return {w, s};
  endfunction
endpackage

// File: rtl/prbs7_word_step.sv
// prbs7_word_step: combinational WORDWIDTH-step PRBS7 unroll, bit 0 generated first
module prbs7_word_step import prbs7_pkg::*; #(
  parameter int WORDWIDTH = 32
) (
  input  logic [6:0]           state,
  output logic [WORDWIDTH-1:0] word,
  output logic [6:0]           next_state
);
  logic [6:0] s;
  always_comb begin
    s = state;
    word = '0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      word[i] = s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
      s = {s[5:0], word[i]};
    end
    next_state = s;
  end
endmodule

// File: rtl/prbs7_tx_source.sv
// prbs7_tx_source: registered PRBS7 word source with seed load, enable and single-bit error injection
module prbs7_tx_source import prbs7_pkg::*; #(
  parameter int         WORDWIDTH = 32,
  parameter logic [6:0] SEED      = 7'h7F,
  parameter int         INJ_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         seed_load,
  input  logic [6:0]                   seed,
  input  logic                         inj_req,
  input  logic [$clog2(WORDWIDTH)-1:0] inj_bit,
  output logic                         inj_ack,
  output logic [WORDWIDTH-1:0]         dout,
  output logic                         dout_valid,
  output logic [31:0]                  word_count,
  output logic [INJ_CNT_W-1:0]         inj_count
);
  localparam logic [6:0] INIT_SEED = (SEED == 7'd0) ? PRBS7_DEFAULT_SEED : SEED;
  logic [6:0] state, next_state;
  logic [WORDWIDTH-1:0] word, mask;
  inj_state_t fsm;
  logic emit, inject;
  prbs7_word_step #(.WORDWIDTH(WORDWIDTH)) u_step (
    .state(state),
    .word(word),
    .next_state(next_state)
  );
  assign emit = en & ~seed_load;
  assign inject = emit & inj_req & (fsm == IDLE);
  assign mask = inject ? (WORDWIDTH'(1) << inj_bit) : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT_SEED;
      dout <= '0;
      dout_valid <= 1'b0;
      inj_ack <= 1'b0;
      word_count <= '0;
      inj_count <= '0;
      fsm <= IDLE;
    end else begin
      dout_valid <= emit;
      inj_ack <= inject;
      if (seed_load) state <= (seed == 7'd0) ? PRBS7_DEFAULT_SEED : seed;
      else if (en) state <= next_state;
      if (emit) begin
        dout <= word ^ mask;
        word_count <= word_count + 32'd1;
      end
      if (inject) begin
        inj_count <= &inj_count ? inj_count : inj_count + 1'b1;
        fsm <= WAIT_REL;
      end else if (fsm == WAIT_REL && !inj_req) fsm <= IDLE;
    end
  end
endmodule

// File: tb/tb_prbs7_tx_source.sv
// tb_prbs7_tx_source: directed self-checking bench against a serial PRBS7 reference
module tb_prbs7_tx_source;
  logic clk = 0, reset = 1, en = 0, seed_load = 0, inj_req = 0;
  logic [6:0] seed = '0;
  logic [4:0] inj_bit = '0;
  logic inj_ack, dout_valid;
  logic [31:0] dout, word_count;
  logic [15:0] inj_count;
  logic en2 = 0, inj_req2 = 0;
  logic [3:0] inj_bit2 = '0;
  logic inj_ack2, dout_valid2;
  logic [11:0] dout2;
  logic [31:0] word_count2;
  logic [1:0] inj_count2;
  int pass_cnt = 0, total = 0;
  logic [6:0] ms, m2;
  logic [63:0] mw, last;
  prbs7_tx_source dut (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed),
    .inj_req(inj_req), .inj_bit(inj_bit), .inj_ack(inj_ack), .dout(dout),
    .dout_valid(dout_valid), .word_count(word_count), .inj_count(inj_count)
  );
  prbs7_tx_source #(.WORDWIDTH(12), .INJ_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .seed_load(1'b0), .seed(7'h00),
    .inj_req(inj_req2), .inj_bit(inj_bit2), .inj_ack(inj_ack2), .dout(dout2),
    .dout_valid(dout_valid2), .word_count(word_count2), .inj_count(inj_count2)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic gen(input int w, inout logic [6:0] s, output logic [63:0] word);
    logic b;
    word = '0;
    for (int i = 0; i < w; i++) begin
      b = s[6] ^ s[5];
      word[i] = b;
      s = {s[5:0], b};
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick;
    tick;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ack", inj_ack, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_ic", inj_count, 0);
    reset = 0;
    en = 1;
    ms = 7'h7F;
    m2 = 7'h7F;
    tick;
    gen(32, ms, mw);
    chk("first_low", dout[15:0], 16'h3040);
    chk("first_word", dout, mw);
    chk("first_valid", dout_valid, 1);
    for (int i = 0; i < 999; i++) begin
      tick;
      gen(32, ms, mw);
      chk("stream", dout, mw);
    end
    chk("wc_1000", word_count, 1000);
    en = 0;
    last = dout;
    repeat (2) begin
      tick;
      chk("pause_dout", dout, last);
      chk("pause_valid", dout_valid, 0);
      chk("pause_wc", word_count, 1000);
    end
    en = 1;
    tick;
    gen(32, ms, mw);
    chk("resume1", dout, mw);
    tick;
    gen(32, ms, mw);
    chk("resume2", dout, mw);
    chk("wc_1002", word_count, 1002);
    seed_load = 1;
    seed = 7'h00;
    last = dout;
    tick;
    chk("load_valid", dout_valid, 0);
    chk("load_dout", dout, last);
    chk("load_wc", word_count, 1002);
    seed_load = 0;
    ms = 7'h7F;
    tick;
    gen(32, ms, mw);
    chk("seed0_low", dout[15:0], 16'h3040);
    chk("seed0_word", dout, mw);
    chk("wc_1003", word_count, 1003);
    inj_bit = 5;
    inj_req = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      gen(32, ms, mw);
      chk("inj_ack", inj_ack, 64'(i == 0));
      chk("inj_word", dout, i == 0 ? mw ^ 64'h20 : mw);
    end
    chk("inj_ic1", inj_count, 1);
    inj_req = 0;
    tick;
    gen(32, ms, mw);
    chk("rel_ack", inj_ack, 0);
    inj_req = 1;
    tick;
    gen(32, ms, mw);
    chk("reinj_ack", inj_ack, 1);
    chk("reinj_word", dout, mw ^ 64'h20);
    chk("inj_ic2", inj_count, 2);
    inj_req = 0;
    tick;
    gen(32, ms, mw);
    en = 0;
    inj_req = 1;
    inj_bit = 0;
    repeat (3) begin
      tick;
      chk("pend_ack", inj_ack, 0);
      chk("pend_valid", dout_valid, 0);
    end
    en = 1;
    tick;
    gen(32, ms, mw);
    chk("pend_fire_ack", inj_ack, 1);
    chk("pend_fire_word", dout, mw ^ 64'h1);
    chk("inj_ic3", inj_count, 3);
    #2 reset = 1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_ack", inj_ack, 0);
    chk("arst_wc", word_count, 0);
    chk("arst_ic", inj_count, 0);
    tick;
    reset = 0;
    ms = 7'h7F;
    m2 = 7'h7F;
    tick;
    gen(32, ms, mw);
    chk("post_rst_ack", inj_ack, 1);
    chk("post_rst_word", dout, mw ^ 64'h1);
    chk("post_rst_wc", word_count, 1);
    chk("post_rst_ic", inj_count, 1);
    inj_req = 0;
    en = 0;
    tick;
    @(negedge clk);
    force dut.word_count = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.word_count;
    en = 1;
    tick;
    gen(32, ms, mw);
    chk("wc_max", word_count, 32'hFFFF_FFFF);
    chk("wc_max_word", dout, mw);
    tick;
    gen(32, ms, mw);
    chk("wc_wrap", word_count, 0);
    en = 0;
    en2 = 1;
    inj_bit2 = 13;
    inj_req2 = 1;
    tick;
    gen(12, m2, mw);
    chk("oob_ack", inj_ack2, 1);
    chk("oob_word", dout2, mw);
    chk("oob_ic", inj_count2, 1);
    inj_req2 = 0;
    tick;
    gen(12, m2, mw);
    chk("w12_word", dout2, mw);
    inj_bit2 = 3;
    for (int i = 0; i < 4; i++) begin
      inj_req2 = 1;
      tick;
      gen(12, m2, mw);
      chk("sat_ack", inj_ack2, 1);
      chk("sat_word", dout2, mw ^ 64'h8);
      chk("sat_ic", inj_count2, i == 0 ? 2 : 3);
      inj_req2 = 0;
      tick;
      gen(12, m2, mw);
      chk("sat_rel_ack", inj_ack2, 0);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
